// File: rtl/ifetch_queue.sv
// Fetch-side queue: owns the fetch PC, drives the 1-cycle-latency instruction SRAM and buffers {pc, inst} for decode.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          kill;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    entry_t        mem [DEPTH];
    entry_t        head;

    logic          resp_valid;
    logic          bypass_valid;
    logic          bypass_take;
    logic          fifo_pop;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;
    logic [CW-1:0] count_after_pop;
    entry_t        resp_entry;

    assign resp_entry = '{pc: req_pc, inst: inst_sram_rdata};
    assign resp_valid = inflight & ~kill & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
    assign bypass_valid = resp_valid & (count == '0);
    assign out_valid    = (count != '0) | bypass_valid;
    assign out_pc       = bypass_valid ? req_pc : head.pc;
    assign out_inst     = bypass_valid ? inst_sram_rdata : head.inst;
`else
    assign bypass_valid = 1'b0;
    assign out_valid    = (count != '0);
    assign out_pc       = head.pc;
    assign out_inst     = head.inst;
`endif

    assign fifo_pop    = (count != '0) & out_ready & ~redirect_valid;
    assign bypass_take = bypass_valid & out_ready;
    assign pop         = fifo_pop | bypass_take;
    // A bypassed response that decode accepts never enters the queue.
    assign push        = resp_valid & ~bypass_take;

    // Slots already committed (queued plus the response still in the SRAM) after this cycle's pop.
    assign occupancy       = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue           = redirect_valid | (occupancy < (CW+1)'(DEPTH));
    assign count_after_pop = count - CW'(fifo_pop);

    assign inst_sram_en   = resetn & issue;
    assign inst_sram_addr = redirect_valid ? redirect_pc : fetch_pc;

    // NOTE: queue storage is not reset; count and head decide what decode ever sees.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= resp_entry;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            head     <= '0;
        end else begin
            kill <= 1'b0;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc + 32'd4;
                req_pc   <= redirect_pc;
                inflight <= 1'b1;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    req_pc   <= fetch_pc;
                    inflight <= 1'b1;
                end else begin
                    inflight <= 1'b0;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(fifo_pop);
                // Head register tracks the next entry; it holds its last value once the queue drains.
                if (push && count_after_pop == '0) begin
                    head <= resp_entry;
                end else if (count_after_pop != '0) begin
                    head <= mem[rd_ptr + AW'(fifo_pop)];
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed testbench for ifetch_queue: startup, fill/drain, redirect flush, redirect vs pop, PC wrap, async reset.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int errors = 0;
    int checks = 0;
    int req_count = 0;
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h1c000000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a == 32'h1c000000) ? 32'h02800421 : (a ^ 32'hA5A50000);
    endfunction

    // Synchronous-read SRAM model, one cycle of latency.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
    end

    // Monitor: count issued requests and record every accepted head.
    always @(posedge clk) begin
        if (resetn && inst_sram_en) req_count++;
        if (resetn && out_valid && out_ready && !redirect_valid) begin
            got_pc.push_back(out_pc);
            got_inst.push_back(out_inst);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc, input logic ready);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        out_ready      = ready;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        inst_sram_rdata = '0;
        #1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", inst_sram_en); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    endtask

    task automatic test_startup();
        resetn = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (inst_sram_en !== 1'b1) begin errors++; $display("FAIL start_en: got %b want 1", inst_sram_en); end
        checks++; if (inst_sram_addr !== 32'h1c000000) begin errors++; $display("FAIL start_addr: got %h want 1c000000", inst_sram_addr); end
        tick();
        for (int k = 1; k < LAT; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL start_early_valid cycle %0d: got %b want 0", k, out_valid); end
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL start_valid: got %b want 1", out_valid); end
        checks++; if (out_pc !== 32'h1c000000) begin errors++; $display("FAIL start_pc0: got %h want 1c000000", out_pc); end
        checks++; if (out_inst !== 32'h02800421) begin errors++; $display("FAIL start_inst0: got %h want 02800421", out_inst); end
        tick();
        checks++; if (out_pc !== 32'h1c000004 || out_valid !== 1'b1) begin errors++; $display("FAIL start_pc1: got %h/%b want 1c000004/1", out_pc, out_valid); end
        checks++; if (out_inst !== inst_of(32'h1c000004)) begin errors++; $display("FAIL start_inst1: got %h want %h", out_inst, inst_of(32'h1c000004)); end
        tick();
        checks++; if (out_pc !== 32'h1c000008 || out_valid !== 1'b1) begin errors++; $display("FAIL start_pc2: got %h/%b want 1c000008/1", out_pc, out_valid); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_pc;
        req_count = 0;
        redirect_to(32'h1c000200, 1'b0);
        repeat (10) tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b want 1", out_valid); end
        checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL fill_en_stall: got %b want 0", inst_sram_en); end
        checks++; if (out_pc !== 32'h1c000200) begin errors++; $display("FAIL fill_head: got %h want 1c000200", out_pc); end
        checks++; if (req_count !== 4) begin errors++; $display("FAIL fill_requests: got %0d want 4", req_count); end
        got_pc.delete(); got_inst.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (got_pc.size() < 5) begin
            errors++; $display("FAIL drain_count: got %0d want >=5", got_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_pc = 32'h1c000200 + 32'(4 * i);
                checks++;
                if (got_pc[i] !== exp_pc || got_inst[i] !== inst_of(exp_pc)) begin
                    errors++; $display("FAIL drain_entry%0d: got %h/%h want %h/%h", i, got_pc[i], got_inst[i], exp_pc, inst_of(exp_pc));
                end
            end
        end
    endtask

    task automatic test_redirect_flush();
        redirect_to(32'h1c000300, 1'b0);
        repeat (3) tick();
        checks++; if (out_pc !== 32'h1c000300 || inst_sram_en !== 1'b0) begin errors++; $display("FAIL flush_setup: got pc %h en %b want 1c000300/0", out_pc, inst_sram_en); end
        redirect_valid = 1'b1; redirect_pc = 32'h1c000100; out_ready = 1'b1;
        #1;
        checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin errors++; $display("FAIL flush_addr: got %b/%h want 1/1c000100", inst_sram_en, inst_sram_addr); end
        got_pc.delete(); got_inst.delete();
        tick();
        redirect_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty cycle %0d: got %b want 0", k, out_valid); end
            tick();
        end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000100) begin errors++; $display("FAIL flush_target: got %b/%h want 1/1c000100", out_valid, out_pc); end
        repeat (3) tick();
        checks++;
        if (got_pc.size() < 3 || got_pc[0] !== 32'h1c000100 || got_pc[1] !== 32'h1c000104 || got_pc[2] !== 32'h1c000108)
        begin errors++; $display("FAIL flush_sequence: got %0d entries, first %h", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx); end
    endtask

    task automatic test_redirect_pop();
        bit seen_old;
        redirect_to(32'h1c000600, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000600) begin errors++; $display("FAIL rpop_setup: got %b/%h want 1/1c000600", out_valid, out_pc); end
        got_pc.delete(); got_inst.delete();
        redirect_to(32'h1c000400, 1'b1);
        checks++;
        if (LAT == 2) begin
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rpop_empty: got %b want 0", out_valid); end
        end else begin
            if (out_pc !== 32'h1c000400) begin errors++; $display("FAIL rpop_bypass: got %h want 1c000400", out_pc); end
        end
        repeat (4) tick();
        checks++; if (got_pc.size() < 1 || got_pc[0] !== 32'h1c000400) begin errors++; $display("FAIL rpop_first: got %0d entries, first %h want 1c000400", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx); end
        seen_old = 1'b0;
        foreach (got_pc[i]) if (got_pc[i] === 32'h1c000600) seen_old = 1'b1;
        checks++; if (seen_old !== 1'b0) begin errors++; $display("FAIL rpop_repeat: old head 1c000600 re-presented"); end
    endtask

    task automatic test_wrap();
        got_pc.delete(); got_inst.delete();
        redirect_to(32'hFFFFFFF8, 1'b1);
        repeat (5) tick();
        checks++;
        if (got_pc.size() < 3 || got_pc[0] !== 32'hFFFFFFF8 || got_pc[1] !== 32'hFFFFFFFC || got_pc[2] !== 32'h00000000)
        begin errors++; $display("FAIL wrap_sequence: got %0d entries, third %h want fffffff8 fffffffc 00000000", got_pc.size(), (got_pc.size() > 2) ? got_pc[2] : 32'hx); end
        checks++; if (got_pc.size() < 3 || got_inst[2] !== inst_of(32'h0)) begin errors++; $display("FAIL wrap_inst: got %h want %h", (got_inst.size() > 2) ? got_inst[2] : 32'hx, inst_of(32'h0)); end
    endtask

    task automatic test_async_reset();
        redirect_to(32'h1c000500, 1'b0);
        repeat (2) tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000500) begin errors++; $display("FAIL areset_setup: got %b/%h want 1/1c000500", out_valid, out_pc); end
        #3 resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0 || inst_sram_en !== 1'b0) begin errors++; $display("FAIL areset_state: got pc %h en %b want 0/0", out_pc, inst_sram_en); end
        tick(); tick();
        got_pc.delete(); got_inst.delete();
        resetn = 1'b1; out_ready = 1'b1;
        repeat (LAT + 2) tick();
        checks++;
        if (got_pc.size() < 1 || got_pc[0] !== 32'h1c000000 || got_inst[0] !== 32'h02800421)
        begin errors++; $display("FAIL areset_restart: got %0d entries, first %h want 1c000000", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_startup();
        test_fill_drain();
        test_redirect_flush();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
